// File: rtl/addsub_seq16.sv
// addsub_seq16: nibble-serial 16-bit add/subtract, one 4-bit slice per cycle, LSB nibble first.
// Define ADDSUB_SEQ16_SAT_EN to saturate s on signed overflow.
module addsub_seq16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        m,
    output logic        busy,
    output logic        done,
    output logic [15:0] s,
    output logic        cout,
    output logic        v
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic [15:0] r_a, r_b, r_s;
    logic [11:0] r_acc;
    logic        r_m, r_c, r_cout, r_v;
    logic [3:0]  w_an, w_bn;
    logic [4:0]  w_sum;
    logic        w_v;
    logic [15:0] w_res, w_fin;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = start ? RUN : IDLE;
        else if (r_state == RUN)
            w_next = (r_cnt == 2'd3) ? DONE : RUN;
        else
            w_next = IDLE;
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
        s    = r_s;
        cout = r_cout;
        v    = r_v;
    end

    // Subtraction is A + ~B + 1: operand B is inverted and the carry is seeded with m.
    always_comb begin
        w_an  = r_a[{r_cnt, 2'b00} +: 4];
        w_bn  = r_b[{r_cnt, 2'b00} +: 4] ^ {4{r_m}};
        w_sum = {1'b0, w_an} + {1'b0, w_bn} + {4'b0000, r_c};
        w_v   = (w_an[3] ^ w_bn[3] ^ w_sum[3]) ^ w_sum[4];
        w_res = {w_sum[3:0], r_acc};
`ifdef ADDSUB_SEQ16_SAT_EN
        w_fin = w_v ? (r_a[15] ? 16'h8000 : 16'h7FFF) : w_res;
`else
        w_fin = w_res;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_c    <= 1'b0;
            r_a    <= 16'h0000;
            r_b    <= 16'h0000;
            r_m    <= 1'b0;
            r_acc  <= 12'h000;
            r_s    <= 16'h0000;
            r_cout <= 1'b0;
            r_v    <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a   <= a;
            r_b   <= b;
            r_m   <= m;
            r_c   <= m;
            r_cnt <= 2'd0;
        end else if (r_state == RUN) begin
            r_acc <= {w_sum[3:0], r_acc[11:4]};
            r_c   <= w_sum[4];
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_s    <= w_fin;
                r_cout <= w_sum[4];
                r_v    <= w_v;
            end
        end
    end
endmodule

// File: doc/addsub_seq16.md
ADDSUB_SEQ16 -- requirements
Module: addsub_seq16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled on the rising edge of clk.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset; overrides every other input.
REQ-004 start  input  1  request to begin one 16-bit operation; honoured only in IDLE.
REQ-005 a  input  16  operand A; sampled on the accept edge only.
REQ-006 b  input  16  operand B; sampled on the accept edge only.
REQ-007 m  input  1  mode, sampled on the accept edge: 0 = A+B, 1 = A-B (two's complement).
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; high only in DONE state.
REQ-010 s  output  16  result; updated only at the end of RUN; held until the next result is written.
REQ-011 cout  output  1  carry out of bit 15 (for m=1: 1 = no borrow); held with s.
REQ-012 v  output  1  signed overflow: carry into bit 15 XOR carry out of bit 15; held with s.

Function
REQ-013 The block SHALL implement a nibble-serial 16-bit add/subtract: one 4-bit add/sub slice evaluated per cycle, least significant nibble first.
REQ-014 The slice SHALL compute operand nibble A + (B nibble XOR {4{m}}) + carry register; the sum nibble goes to an internal accumulator and the carry-out goes back to the carry register.
REQ-015 FSM states are IDLE, RUN and DONE; the nibble counter is 2 bits.
REQ-016 IDLE->RUN on an edge with start=1 (the "accept edge" E0): latch a, b and m; set carry register to m; set counter to 0.
REQ-017 In RUN, edges E1..E4 SHALL each process nibble[counter] and increment the counter; the counter wraps 3->0 at E4.
REQ-018 At E4: s <= accumulator, including the nibble 3 sum; cout <= slice carry-out; v <= carry into bit 15 XOR carry-out; state -> DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then go to IDLE; latency is done high in the cycle after E4, i.e. 4 edges after accept.
REQ-020 start while busy=1 (RUN or DONE) SHALL be ignored with no queuing; the next accept is possible at the first edge in IDLE.
REQ-021 Changes on a, b or m after the accept edge SHALL NOT affect the result in progress.
REQ-022 s, cout and v SHALL change only at E4 (or on reset); intermediate nibbles are never visible on s.

Reset
REQ-023 rst=1 at an edge SHALL force: state=IDLE, counter=0, carry=0, busy=0, done=0, s=16'h0000, cout=0, v=0.
REQ-024 rst during RUN or DONE SHALL abort the operation; done SHALL NOT assert for the aborted operation.
REQ-025 rst=1 together with start=1 SHALL cause reset only, with no accept.

Configuration
REQ-026 Macro ADDSUB_SEQ16_SAT_EN: when defined and the final v=1, s SHALL be 16'h7FFF if latched a[15]=0, else 16'h8000; cout and v still report the raw values.
REQ-027 Without ADDSUB_SEQ16_SAT_EN, s SHALL be the wrapped 16-bit result; no saturation logic is present.

Verification
REQ-028 a=16'h1234, b=16'h0FFF, m=0 -> s=16'h2233, cout=0, v=0, with done high exactly 4 edges after accept and busy high during RUN and DONE.
REQ-029 a=16'h7FFF, b=16'h0001, m=0 -> v=1, cout=0; s=16'h8000 without the macro, s=16'h7FFF with ADDSUB_SEQ16_SAT_EN.
REQ-030 a=16'h0005, b=16'h0007, m=1 -> s=16'hFFFE, cout=0, v=0; then a=16'h8000, b=16'h0001, m=1 -> v=1, cout=1, s=16'h7FFF without the macro, 16'h8000 with it.
REQ-031 start pulsed again at E2 with different operands -> ignored, first result is unchanged, and only one done pulse occurs; start held high continuously -> back-to-back operations, each accepted on the first IDLE edge.
REQ-032 rst asserted at E2 of an operation -> done never pulses, and s, cout, v, busy all read 0; the next start is accepted normally.
REQ-033 a and b toggled every cycle after accept -> the result matches the operands latched at the accept edge.
